ps2_teclado_rx: RTL

//  PS/2 keyboard receiver: the stage directly upstream of the temperature/pressure control top.

---
 rtl/ps2_teclado_rx_pkg.sv | 28 ++
 rtl/ps2_teclado_rx_if.sv | 11 +
 rtl/ps2_teclado_rx_filtro.sv | 48 ++++
 rtl/ps2_teclado_rx.sv | 135 +++++++++++++
 4 files changed

// File: rtl/ps2_teclado_rx_pkg.sv
// Shared constants, state encoding and frame layout for the PS/2 keyboard receiver.
package ps2_teclado_rx_pkg;

  localparam logic [7:0]  COD_BREAK        = 8'hF0;
  localparam logic [7:0]  COD_EXT          = 8'hE0;
  localparam logic [7:0]  TECLA_NULA       = 8'h00;
  localparam int unsigned TRAMA_BITS       = 11;
  localparam int unsigned BITS_TRAS_INICIO = TRAMA_BITS - 1;
  localparam int unsigned NBITS_W          = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECIBE = 2'd1,
    VALIDA = 2'd2
  } estado_t;

  // Frame as it sits in the shift register once the stop bit has been shifted in.
  typedef struct packed {
    logic       stop;
    logic       paridad;
    logic [7:0] dato;
  } trama_t;

  function automatic logic paridad_ok(input trama_t t);
    return ^{t.paridad, t.dato};
  endfunction

endpackage

// File: rtl/ps2_teclado_rx_if.sv
// Keyboard line inputs and decoded key outputs of the PS/2 receiver.
interface ps2_teclado_rx_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] tecla;
  logic       tecla_nueva;
  logic       err_trama;

  modport slave  (input  ps2_clk, ps2_data, output tecla, tecla_nueva, err_trama);
  modport master (output ps2_clk, ps2_data, input  tecla, tecla_nueva, err_trama);
endinterface

// File: rtl/ps2_teclado_rx_filtro.sv
// Synchronizes both PS/2 lines, debounces ps2_clk and strobes once per accepted falling edge.
module ps2_teclado_rx_filtro #(
  parameter int unsigned FILTRO_N = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic i_ps2_clk,
  input  logic i_ps2_data,
  output logic o_bit_strobe,
  output logic o_dato_sync
);

  localparam int unsigned CW = (FILTRO_N > 1) ? $clog2(FILTRO_N) : 1;

  logic [1:0]    r_clk_sync;
  logic [1:0]    r_dat_sync;
  logic          r_clk_filt;
  logic [CW-1:0] r_cnt;
  logic          r_strobe;

  logic w_difiere;
  logic w_acepta;

  // A level change is accepted on the FILTRO_N-th consecutive differing sample.
  assign w_difiere = (r_clk_sync[1] != r_clk_filt);
  assign w_acepta  = w_difiere && (r_cnt == CW'(FILTRO_N - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_clk_sync <= 2'b11;
      r_dat_sync <= 2'b11;
      r_clk_filt <= 1'b1;
      r_cnt      <= '0;
      r_strobe   <= 1'b0;
    end else begin
      r_clk_sync <= {r_clk_sync[0], i_ps2_clk};
      r_dat_sync <= {r_dat_sync[0], i_ps2_data};
      if (!w_difiere || w_acepta) r_cnt <= '0;
      else                        r_cnt <= r_cnt + CW'(1);
      if (w_acepta) r_clk_filt <= r_clk_sync[1];
      r_strobe <= w_acepta && r_clk_filt;
    end
  end

  assign o_bit_strobe = r_strobe;
  assign o_dato_sync  = r_dat_sync[1];

endmodule

// File: rtl/ps2_teclado_rx.sv
// PS/2 keyboard receiver: deframes 11-bit frames, tracks E0/F0 prefixes, holds the last make code.
// Optional odd-parity check enabled by defining PARITY_CHECK_EN.
module ps2_teclado_rx
  import ps2_teclado_rx_pkg::*;
#(
  parameter int unsigned FILTRO_N       = 8,
  parameter int unsigned TIMEOUT_CICLOS = 50000
) (
  input logic              clk,
  input logic              reset,
  ps2_teclado_rx_if.slave  bus
);

  localparam int unsigned TW = $clog2(TIMEOUT_CICLOS + 1);

  logic               w_strobe;
  logic               w_dato;
  estado_t            r_estado;
  estado_t            w_estado_sig;
  trama_t             r_trama;
  logic [NBITS_W-1:0] r_nbits;
  logic [TW-1:0]      r_to;
  logic               r_flag_ext;
  logic               r_flag_break;
  logic [7:0]         r_tecla;
  logic               r_nueva;
  logic               r_err;

  logic               w_ultimo;
  logic               w_timeout;
  logic               w_trama_ok;
  logic [7:0]         w_tecla_sig;
  logic               w_nueva_sig;
  logic               w_err_sig;
  logic               w_ext_sig;
  logic               w_break_sig;

  ps2_teclado_rx_filtro #(.FILTRO_N(FILTRO_N)) u_filtro (
    .clk          (clk),
    .reset        (reset),
    .i_ps2_clk    (bus.ps2_clk),
    .i_ps2_data   (bus.ps2_data),
    .o_bit_strobe (w_strobe),
    .o_dato_sync  (w_dato)
  );

  // r_to holds the number of cycles elapsed since the last strobe.
  assign w_ultimo  = w_strobe && (r_nbits == NBITS_W'(BITS_TRAS_INICIO - 1));
  assign w_timeout = !w_strobe && (r_to == TW'(TIMEOUT_CICLOS - 1));

`ifdef PARITY_CHECK_EN
  assign w_trama_ok = r_trama.stop && paridad_ok(r_trama);
`else
  assign w_trama_ok = r_trama.stop;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_estado <= IDLE;
    else       r_estado <= w_estado_sig;
  end

  always_comb begin
    w_estado_sig = r_estado;
    case (r_estado)
      IDLE:    if (w_strobe && !w_dato) w_estado_sig = RECIBE;
      RECIBE:  if (w_ultimo)            w_estado_sig = VALIDA;
               else if (w_timeout)      w_estado_sig = IDLE;
      VALIDA:                           w_estado_sig = IDLE;
      default:                          w_estado_sig = IDLE;
    endcase
  end

  // Decode of a completed frame and the timeout error.
  always_comb begin
    w_tecla_sig = r_tecla;
    w_nueva_sig = 1'b0;
    w_err_sig   = 1'b0;
    w_ext_sig   = r_flag_ext;
    w_break_sig = r_flag_break;
    case (r_estado)
      RECIBE: if (!w_ultimo && w_timeout) w_err_sig = 1'b1;
      VALIDA: begin
        if (!w_trama_ok) begin
          w_err_sig = 1'b1;
        end else if (r_trama.dato == COD_EXT) begin
          w_ext_sig = 1'b1;
        end else if (r_trama.dato == COD_BREAK) begin
          w_break_sig = 1'b1;
        end else if (r_flag_break) begin
          if (r_trama.dato == r_tecla) w_tecla_sig = TECLA_NULA;
          w_ext_sig   = 1'b0;
          w_break_sig = 1'b0;
        end else begin
          w_tecla_sig = r_trama.dato;
          w_nueva_sig = 1'b1;
          w_ext_sig   = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_trama      <= '0;
      r_nbits      <= '0;
      r_to         <= '0;
      r_flag_ext   <= 1'b0;
      r_flag_break <= 1'b0;
      r_tecla      <= TECLA_NULA;
      r_nueva      <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      if (r_estado == IDLE && w_strobe && !w_dato) begin
        r_nbits <= '0;
      end else if (r_estado == RECIBE && w_strobe) begin
        r_trama <= {w_dato, r_trama[9:1]};
        r_nbits <= r_nbits + NBITS_W'(1);
      end
      if (w_strobe)                r_to <= TW'(1);
      else if (r_estado == RECIBE) r_to <= r_to + TW'(1);
      else                         r_to <= '0;
      r_flag_ext   <= w_ext_sig;
      r_flag_break <= w_break_sig;
      r_tecla      <= w_tecla_sig;
      r_nueva      <= w_nueva_sig;
      r_err        <= w_err_sig;
    end
  end

  assign bus.tecla       = r_tecla;
  assign bus.tecla_nueva = r_nueva;
  assign bus.err_trama   = r_err;

endmodule
